// File: rtl/dsp_mac_seq_pkg.sv
// dsp_mac_seq_pkg: shared state type, datapath widths and DSP mode constants
package dsp_mac_seq_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DRAIN} mac_state_t;
  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int Z_W = 38;
  localparam logic [2:0] OSEL_ACC = 3'd1;
  localparam logic [2:0] FB_ACC = 3'd0;
endpackage

// File: rtl/dsp_mac_seq_coef_rf.sv
// dsp_mac_seq_coef_rf: coefficient register file, writable only while idle, with drop flag
module dsp_mac_seq_coef_rf
  import dsp_mac_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW = $clog2(NTAPS)
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           we_i,
  input  logic [AW-1:0]  addr_i,
  input  logic [B_W-1:0] data_i,
  input  logic           idle_i,
  input  logic [AW-1:0]  rd_addr_i,
  output logic [B_W-1:0] rd_data_o,
  output logic           drop_o
);
  logic [B_W-1:0] coef_q [NTAPS];
  logic [B_W-1:0] coef_d [NTAPS];
  logic drop_q, drop_d, wr_ok;
  // accept in-range writes while idle, flag every other write as dropped
  always_comb begin
    wr_ok = we_i && idle_i && (32'(addr_i) < NTAPS);
    drop_d = we_i && !wr_ok;
    for (int k = 0; k < NTAPS; k++) coef_d[k] = (wr_ok && 32'(addr_i) == k) ? data_i : coef_q[k];
  end
  // coefficient storage and one-cycle drop pulse
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      coef_q <= '{default: '0};
      drop_q <= 1'b0;
    end else begin
      coef_q <= coef_d;
      drop_q <= drop_d;
    end
  end
  assign rd_data_o = coef_q[rd_addr_i];
  assign drop_o = drop_q;
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: time-multiplexed FIR controller driving one accumulating DSP block
module dsp_mac_sequencer
  import dsp_mac_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DSP_LAT = 1,
  parameter logic UNSIGNED_A = 1'b0,
  parameter logic UNSIGNED_B = 1'b0,
  localparam int AW = $clog2(NTAPS)
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  input  logic [A_W-1:0] s_data_i,
  input  logic           coef_we_i,
  input  logic [AW-1:0]  coef_addr_i,
  input  logic [B_W-1:0] coef_data_i,
  output logic           coef_drop_o,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic [Z_W-1:0] m_data_o,
  output logic [A_W-1:0] a_o,
  output logic [B_W-1:0] b_o,
  output logic           load_acc_o,
  output logic [2:0]     feedback_o,
  output logic [2:0]     output_select_o,
  output logic           subtract_o,
  output logic           unsigned_a_o,
  output logic           unsigned_b_o,
  input  logic [Z_W-1:0] z_i
);
  mac_state_t state_q, state_d;
  logic [AW-1:0] tap_q, tap_d;
  logic [1:0] lat_q, lat_d;
  logic [A_W-1:0] dl_q [NTAPS];
  logic [A_W-1:0] dl_d [NTAPS];
  logic m_valid_q, m_valid_d;
  logic [Z_W-1:0] m_data_q, m_data_d;
  logic [B_W-1:0] coef_rd;
  logic accept, last_tap, last_drain, capture;

  assign accept = s_valid_i && s_ready_o;
  assign last_tap = tap_q == AW'(NTAPS - 1);
  assign last_drain = lat_q == 2'(DSP_LAT - 1);
  assign capture = state_q == DRAIN && last_drain;

  dsp_mac_seq_coef_rf #(.NTAPS(NTAPS), .AW(AW)) u_coef_rf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .we_i      (coef_we_i),
    .addr_i    (coef_addr_i),
    .data_i    (coef_data_i),
    .idle_i    (state_q == IDLE),
    .rd_addr_i (tap_q),
    .rd_data_o (coef_rd),
    .drop_o    (coef_drop_o)
  );

  // state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: one MAC per tap, then wait out the DSP latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? MAC : IDLE;
      MAC:     state_d = last_tap ? DRAIN : MAC;
      DRAIN:   state_d = last_drain ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // DSP drive and stream handshake; accumulator holds outside MAC
  always_comb begin
    s_ready_o = state_q == IDLE && (!m_valid_q || m_ready_i);
    a_o = state_q == MAC ? dl_q[tap_q] : '0;
    b_o = state_q == MAC ? coef_rd : '0;
    load_acc_o = !(state_q == MAC && tap_q == '0);
  end

  // tap/drain counters, delay line shift and output buffer
  always_comb begin
    tap_d = (state_q == MAC && !last_tap) ? tap_q + 1'b1 : '0;
    lat_d = (state_q == DRAIN && !last_drain) ? lat_q + 1'b1 : '0;
    dl_d[0] = accept ? s_data_i : dl_q[0];
    for (int k = 1; k < NTAPS; k++) dl_d[k] = accept ? dl_q[k-1] : dl_q[k];
    m_valid_d = capture ? 1'b1 : (m_ready_i ? 1'b0 : m_valid_q);
    m_data_d = capture ? z_i : m_data_q;
  end

  // datapath registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tap_q <= '0;
      lat_q <= '0;
      dl_q <= '{default: '0};
      m_valid_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      tap_q <= tap_d;
      lat_q <= lat_d;
      dl_q <= dl_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o = m_data_q;
  assign feedback_o = FB_ACC;
  assign output_select_o = OSEL_ACC;
  assign subtract_o = 1'b0;
  assign unsigned_a_o = UNSIGNED_A;
  assign unsigned_b_o = UNSIGNED_B;
endmodule
